// File: rtl/alu_pkg.sv
// alu_pkg: word width and opcode constants shared by the alu and its decoder
package alu_pkg;
  localparam int WORD_SIZE = 16;
  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_MUL   = 3'd2;
  localparam logic [2:0] ALU_SLT   = 3'd3;
  localparam logic [2:0] ALU_AND   = 3'd4;
  localparam logic [2:0] ALU_OR    = 3'd5;
  localparam logic [2:0] ALU_XOR   = 3'd6;
  localparam logic [2:0] ALU_SHIFT = 3'd7;
endpackage

// File: rtl/alu_shifter.sv
// alu_shifter: combinational logical shifter, a = operand, b = signed count (>=0 left, <0 right), y = result
module alu_shifter
  import alu_pkg::*;
(
  input  logic [0:WORD_SIZE-1] a,
  input  logic [0:WORD_SIZE-1] b,
  output logic [0:WORD_SIZE-1] y
);
  logic                 neg;
  logic [0:WORD_SIZE-1] mag;
  always_comb begin
    neg = b[0];
    mag = neg ? -b : b;
    y   = neg ? a >> mag : a << mag;
  end
endmodule

// File: rtl/alu.sv
// alu: registered 8-op ALU, op/in1/in2 sampled on rising clk, out = result one cycle later, reset = sync active-high clear
module alu
  import alu_pkg::*;
(
  input  logic [2:0]           op,
  input  logic [0:WORD_SIZE-1] in1,
  input  logic [0:WORD_SIZE-1] in2,
  input  logic                 clk,
  output logic [0:WORD_SIZE-1] out,
  input  logic                 reset
);
  logic [0:WORD_SIZE-1] res;
  logic [0:WORD_SIZE-1] shf;
  alu_shifter u_shifter (
    .a (in1),
    .b (in2),
    .y (shf)
  );
  always_comb begin
    res = '0;
    case (op)
      ALU_ADD:   res = in1 + in2;
      ALU_SUB:   res = in1 - in2;
      ALU_MUL:   res = in1 * in2;
      ALU_SLT:   res = {{(WORD_SIZE-1){1'b0}}, $signed(in1) < $signed(in2)};
      ALU_AND:   res = in1 & in2;
      ALU_OR:    res = in1 | in2;
      ALU_XOR:   res = in1 ^ in2;
      default:   res = shf;
    endcase
  end
  always_ff @(posedge clk)
    out <= reset ? '0 : res;
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed-vector self-checking bench for alu
module tb_alu;
  import alu_pkg::*;
  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [2:0]           op = ALU_ADD;
  logic [0:WORD_SIZE-1] in1 = '0;
  logic [0:WORD_SIZE-1] in2 = '0;
  logic [0:WORD_SIZE-1] out;
  int passed = 0;
  int total = 0;
  alu dut (
    .op    (op),
    .in1   (in1),
    .in2   (in2),
    .clk   (clk),
    .out   (out),
    .reset (reset)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [0:WORD_SIZE-1] got, input logic [0:WORD_SIZE-1] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic run(input string tag, input logic [2:0] o, input logic [0:WORD_SIZE-1] a,
                     input logic [0:WORD_SIZE-1] b, input logic r, input logic [0:WORD_SIZE-1] exp);
    op = o;
    in1 = a;
    in2 = b;
    reset = r;
    @(posedge clk);
    #1;
    check(tag, out, exp);
  endtask
  initial begin
    run("rst1",       ALU_ADD,   16'd5,     16'd7,     1'b1, 16'd0);
    run("rst2",       ALU_ADD,   16'd5,     16'd7,     1'b1, 16'd0);
    run("rst_rel",    ALU_ADD,   16'd5,     16'd7,     1'b0, 16'd12);
    run("add",        ALU_ADD,   16'd5,     16'd7,     1'b0, 16'd12);
    run("sub",        ALU_SUB,   16'd15,    16'd4,     1'b0, 16'd11);
    run("mul",        ALU_MUL,   16'd4,     16'd9,     1'b0, 16'd36);
    run("slt",        ALU_SLT,   16'd5,     16'd7,     1'b0, 16'd1);
    run("and",        ALU_AND,   16'd9,     16'd12,    1'b0, 16'd8);
    run("or",         ALU_OR,    16'd9,     16'd12,    1'b0, 16'd13);
    run("xor",        ALU_XOR,   16'd9,     16'd12,    1'b0, 16'd5);
    run("shl",        ALU_SHIFT, 16'd5,     16'd3,     1'b0, 16'd40);
    run("add_wrap",   ALU_ADD,   16'hFFFF,  16'd1,     1'b0, 16'h0000);
    run("sub_wrap",   ALU_SUB,   16'd0,     16'd1,     1'b0, 16'hFFFF);
    run("mul_hi",     ALU_MUL,   16'h0100,  16'h0100,  1'b0, 16'h0000);
    run("mul_trunc",  ALU_MUL,   16'd300,   16'd300,   1'b0, 16'h5F90);
    run("slt_neg",    ALU_SLT,   16'hFFFF,  16'd1,     1'b0, 16'd1);
    run("slt_pos",    ALU_SLT,   16'd1,     16'hFFFF,  1'b0, 16'd0);
    run("slt_eq",     ALU_SLT,   16'd7,     16'd7,     1'b0, 16'd0);
    run("shr1",       ALU_SHIFT, 16'h8001,  16'hFFFF,  1'b0, 16'h4000);
    run("shl15",      ALU_SHIFT, 16'd1,     16'd15,    1'b0, 16'h8000);
    run("shl16",      ALU_SHIFT, 16'd1,     16'd16,    1'b0, 16'h0000);
    run("shr_min",    ALU_SHIFT, 16'hFFFF,  16'h8000,  1'b0, 16'h0000);
    run("sh0",        ALU_SHIFT, 16'd7,     16'd0,     1'b0, 16'd7);
    run("shr_m16",    ALU_SHIFT, 16'hFFFF,  16'hFFF0,  1'b0, 16'h0000);
    run("shr_m15",    ALU_SHIFT, 16'h8000,  16'hFFF1,  1'b0, 16'h0001);
    run("mid_rst",    ALU_ADD,   16'd5,     16'd7,     1'b1, 16'd0);
    run("post_rst",   ALU_ADD,   16'd5,     16'd7,     1'b0, 16'd12);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
